// File: rtl/mem_bank_router_if.sv
// Bundle of the two-master command/return bus and the N-bank RAM ports of mem_bank_router.
// The master modport is the environment side (requesters and RAMs). The slave modport is the router.
interface mem_bank_router_if #(
  parameter int N_BANKS = 2,
  parameter int ID_W    = 3,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
);
  // Handshake: a command for master k transfers on a cycle where m_req[k] and m_ready[k] are both high.
  // m_req[k] and its id/addr/wdata/wren hold until that cycle. m_ready is a combinational function of m_req.
  logic [1:0]                m_req;
  logic [1:0]                m_ready;
  logic [2*ID_W-1:0]         m_id;
  logic [2*ADDR_W-1:0]       m_addr;
  logic [2*DATA_W-1:0]       m_wdata;
  logic [1:0]                m_wren;
  logic [1:0]                m_rvalid;
  logic [2*DATA_W-1:0]       m_rdata;
  logic [1:0]                m_err;
  logic [N_BANKS*ADDR_W-1:0] bank_addr;
  logic [N_BANKS*DATA_W-1:0] bank_data;
  logic [N_BANKS-1:0]        bank_wren;
  logic [N_BANKS*DATA_W-1:0] bank_q;

  modport master (
    output m_req, m_id, m_addr, m_wdata, m_wren, bank_q,
    input  m_ready, m_rvalid, m_rdata, m_err, bank_addr, bank_data, bank_wren
  );

  modport slave (
    input  m_req, m_id, m_addr, m_wdata, m_wren, bank_q,
    output m_ready, m_rvalid, m_rdata, m_err, bank_addr, bank_data, bank_wren
  );
endinterface

// File: rtl/mem_bank_router.sv
// Two-master round-robin router onto N single-port synchronous RAM banks with a read-return pipeline.
// Optional MEM_BANK_ROUTER_BCAST_EN: an all-ones id writes every bank at once (broadcast reads are invalid).
module mem_bank_router #(
  parameter int N_BANKS = 2,
  parameter int ID_W    = 3,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int RD_LAT  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  mem_bank_router_if.slave bus
);

  typedef struct packed {
    logic            valid;
    logic            master;
    logic [ID_W-1:0] id;
    logic            err;
  } rd_tag_t;

  logic                      ptr_q, ptr_d;
  logic [N_BANKS*ADDR_W-1:0] bank_addr_q, bank_addr_d;
  logic [N_BANKS*DATA_W-1:0] bank_data_q, bank_data_d;
  logic [N_BANKS-1:0]        bank_wren_q, bank_wren_d;
  logic [1:0]                m_rvalid_q, m_rvalid_d;
  logic [1:0]                m_err_q, m_err_d;
  logic [2*DATA_W-1:0]       m_rdata_q, m_rdata_d;
  // Stage 0 is the bank-port cycle; stage RD_LAT is the cycle bank_q carries the read data.
  rd_tag_t                   pipe_q [RD_LAT+1];
  rd_tag_t                   pipe_d [RD_LAT+1];

  logic [1:0]        grant;
  logic              accept;
  logic              sel;
  logic [ID_W-1:0]   sel_id;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_wren;
  logic              id_valid;
  logic              is_bcast;
  logic              cmd_err;
  logic [DATA_W-1:0] tail_data;

  always_comb begin
    if (bus.m_req == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
    else                    grant = bus.m_req;
    accept    = |grant;
    sel       = grant[1];
    sel_id    = sel ? bus.m_id[2*ID_W-1:ID_W]       : bus.m_id[ID_W-1:0];
    sel_addr  = sel ? bus.m_addr[2*ADDR_W-1:ADDR_W] : bus.m_addr[ADDR_W-1:0];
    sel_wdata = sel ? bus.m_wdata[2*DATA_W-1:DATA_W] : bus.m_wdata[DATA_W-1:0];
    sel_wren  = sel ? bus.m_wren[1] : bus.m_wren[0];
    id_valid  = 32'(sel_id) < 32'(N_BANKS);
`ifdef MEM_BANK_ROUTER_BCAST_EN
    is_bcast  = (sel_id == {ID_W{1'b1}});
`else
    is_bcast  = 1'b0;
`endif
    // A broadcast write is legal; a broadcast read falls through to the invalid-id path.
    cmd_err   = ~id_valid & ~(is_bcast & sel_wren);

    ptr_d       = accept ? ~sel : ptr_q;
    bank_addr_d = bank_addr_q;
    bank_data_d = bank_data_q;
    bank_wren_d = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      if (accept && ((id_valid && sel_id == ID_W'(b)) || (is_bcast && sel_wren))) begin
        bank_addr_d[b*ADDR_W +: ADDR_W] = sel_addr;
        bank_data_d[b*DATA_W +: DATA_W] = sel_wdata;
        bank_wren_d[b]                  = sel_wren;
      end
    end

    m_err_d = '0;
    if (accept && cmd_err) begin
      if (sel) m_err_d[1] = 1'b1;
      else     m_err_d[0] = 1'b1;
    end

    pipe_d[0].valid  = accept & ~sel_wren;
    pipe_d[0].master = sel;
    pipe_d[0].id     = sel_id;
    pipe_d[0].err    = cmd_err;
    for (int k = 1; k <= RD_LAT; k++) pipe_d[k] = pipe_q[k-1];

    // Invalid ids match no bank, so their returned data stays zero.
    tail_data = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      if (!pipe_q[RD_LAT].err && pipe_q[RD_LAT].id == ID_W'(b))
        tail_data = bus.bank_q[b*DATA_W +: DATA_W];
    end

    m_rvalid_d = '0;
    m_rdata_d  = m_rdata_q;
    if (pipe_q[RD_LAT].valid) begin
      if (pipe_q[RD_LAT].master) begin
        m_rvalid_d[1]                  = 1'b1;
        m_rdata_d[2*DATA_W-1:DATA_W]   = tail_data;
      end else begin
        m_rvalid_d[0]                  = 1'b1;
        m_rdata_d[DATA_W-1:0]          = tail_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q       <= 1'b0;
      bank_addr_q <= '0;
      bank_data_q <= '0;
      bank_wren_q <= '0;
      m_rvalid_q  <= '0;
      m_err_q     <= '0;
      m_rdata_q   <= '0;
      for (int k = 0; k <= RD_LAT; k++) pipe_q[k] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      bank_addr_q <= bank_addr_d;
      bank_data_q <= bank_data_d;
      bank_wren_q <= bank_wren_d;
      m_rvalid_q  <= m_rvalid_d;
      m_err_q     <= m_err_d;
      m_rdata_q   <= m_rdata_d;
      for (int k = 0; k <= RD_LAT; k++) pipe_q[k] <= pipe_d[k];
    end
  end

  assign bus.m_ready   = grant;
  assign bus.m_rvalid  = m_rvalid_q;
  assign bus.m_rdata   = m_rdata_q;
  assign bus.m_err     = m_err_q;
  assign bus.bank_addr = bank_addr_q;
  assign bus.bank_data = bank_data_q;
  assign bus.bank_wren = bank_wren_q;

endmodule

// File: tb/tb_mem_bank_router.sv
// Directed bench for mem_bank_router: one instance with RD_LAT=1 and one with RD_LAT=3, each on behavioural RAMs.
module tb_mem_bank_router;
  localparam int NB = 2;
  localparam int IW = 3;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_bank_router_if #(.N_BANKS(NB), .ID_W(IW), .ADDR_W(AW), .DATA_W(DW)) ia ();
  mem_bank_router_if #(.N_BANKS(NB), .ID_W(IW), .ADDR_W(AW), .DATA_W(DW)) ib ();

  mem_bank_router #(.N_BANKS(NB), .ID_W(IW), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ia)
  );
  mem_bank_router #(.N_BANKS(NB), .ID_W(IW), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ib)
  );

  // RAM models: read-before-write, one registered read stage (a) or three (b).
  logic [DW-1:0] mem_a [NB][256];
  logic [DW-1:0] mem_b [NB][256];
  logic [DW-1:0] qb_s1 [NB];
  logic [DW-1:0] qb_s2 [NB];

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (!reset_n) begin
        for (int i = 0; i < 256; i++) begin
          mem_a[b][i] <= '0;
          mem_b[b][i] <= '0;
        end
      end else begin
        if (ia.bank_wren[b]) mem_a[b][ia.bank_addr[b*AW +: AW]] <= ia.bank_data[b*DW +: DW];
        if (ib.bank_wren[b]) mem_b[b][ib.bank_addr[b*AW +: AW]] <= ib.bank_data[b*DW +: DW];
      end
      ia.bank_q[b*DW +: DW] <= mem_a[b][ia.bank_addr[b*AW +: AW]];
      qb_s1[b]              <= mem_b[b][ib.bank_addr[b*AW +: AW]];
      qb_s2[b]              <= qb_s1[b];
      ib.bank_q[b*DW +: DW] <= qb_s2[b];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int m, input logic req, input logic [IW-1:0] id,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd, input logic wr);
    ia.m_req[m]            = req;
    ia.m_id[m*IW +: IW]    = id;
    ia.m_addr[m*AW +: AW]  = addr;
    ia.m_wdata[m*DW +: DW] = wd;
    ia.m_wren[m]           = wr;
  endtask

  task automatic set_b(input int m, input logic req, input logic [IW-1:0] id,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd, input logic wr);
    ib.m_req[m]            = req;
    ib.m_id[m*IW +: IW]    = id;
    ib.m_addr[m*AW +: AW]  = addr;
    ib.m_wdata[m*DW +: DW] = wd;
    ib.m_wren[m]           = wr;
  endtask

  task automatic idle_a();
    set_a(0, 1'b0, '0, '0, '0, 1'b0);
    set_a(1, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic idle_b();
    set_b(0, 1'b0, '0, '0, '0, 1'b0);
    set_b(1, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic test_reset();
    n_vec++;
    if ({ia.m_ready, ia.m_rvalid, ia.m_err, ia.bank_wren, ia.bank_addr, ia.bank_data, ia.m_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_a got %b %b %b %b %h %h %h exp all zero", ia.m_ready, ia.m_rvalid, ia.m_err,
               ia.bank_wren, ia.bank_addr, ia.bank_data, ia.m_rdata);
    end
    n_vec++;
    if ({ib.m_ready, ib.m_rvalid, ib.m_err, ib.bank_wren, ib.bank_addr, ib.bank_data, ib.m_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_b got %b %b %b %b %h %h %h exp all zero", ib.m_ready, ib.m_rvalid, ib.m_err,
               ib.bank_wren, ib.bank_addr, ib.bank_data, ib.m_rdata);
    end
  endtask

  task automatic test_write_read();
    tick(); set_a(0, 1'b1, 3'd0, 8'h10, 8'hA5, 1'b1); #1;
    n_vec++;
    if (ia.m_ready !== 2'b01) begin n_err++; $display("FAIL wr_grant got %b exp 01", ia.m_ready); end
    tick();
    n_vec++;
    if ({ia.bank_wren, ia.bank_addr[7:0], ia.bank_data[7:0], ia.m_err} !== {2'b01, 8'h10, 8'hA5, 2'b00}) begin
      n_err++;
      $display("FAIL wr_port got wren=%b addr=%h data=%h err=%b exp wren=01 addr=10 data=a5 err=00",
               ia.bank_wren, ia.bank_addr[7:0], ia.bank_data[7:0], ia.m_err);
    end
    set_a(0, 1'b1, 3'd0, 8'h10, 8'h00, 1'b0); #1;
    n_vec++;
    if (ia.m_ready !== 2'b01) begin n_err++; $display("FAIL rd_grant got %b exp 01", ia.m_ready); end
    tick(); idle_a(); #1;
    n_vec++;
    if (ia.bank_wren !== 2'b00) begin n_err++; $display("FAIL wr_one_cycle got %b exp 00", ia.bank_wren); end
    tick();
    n_vec++;
    if (ia.m_rvalid !== 2'b00) begin n_err++; $display("FAIL rd_early got %b exp 00", ia.m_rvalid); end
    tick();
    n_vec++;
    if ({ia.m_rvalid, ia.m_rdata} !== {2'b01, 8'h00, 8'hA5}) begin
      n_err++; $display("FAIL rd_return got %b %h exp 01 00a5", ia.m_rvalid, ia.m_rdata);
    end
    tick();
    n_vec++;
    if ({ia.m_rvalid, ia.m_rdata} !== {2'b00, 8'h00, 8'hA5}) begin
      n_err++; $display("FAIL rd_hold got %b %h exp 00 00a5", ia.m_rvalid, ia.m_rdata);
    end
  endtask

  task automatic test_alternate();
    logic [1:0]  exp_ready [4];
    logic [17:0] exp_rd [8];
    exp_ready = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_rd = '{{2'b00, 8'h00, 8'hA5}, {2'b00, 8'h00, 8'hA5}, {2'b00, 8'h00, 8'hA5}, {2'b01, 8'h00, 8'h5A},
               {2'b10, 8'hA5, 8'h5A}, {2'b01, 8'hA5, 8'h5A}, {2'b10, 8'hA5, 8'h5A}, {2'b00, 8'hA5, 8'h5A}};
    tick(); set_a(1, 1'b1, 3'd1, 8'h10, 8'h5A, 1'b1); #1;
    n_vec++;
    if (ia.m_ready !== 2'b10) begin n_err++; $display("FAIL m1_wr_grant got %b exp 10", ia.m_ready); end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) begin
        set_a(0, 1'b1, 3'd1, 8'h10, 8'h00, 1'b0);
        set_a(1, 1'b1, 3'd0, 8'h10, 8'h00, 1'b0);
        n_vec++;
        if (ia.bank_wren !== 2'b10) begin n_err++; $display("FAIL m1_wr_port got %b exp 10", ia.bank_wren); end
      end
      if (i == 4) idle_a();
      #1;
      n_vec++;
      if (ia.m_ready !== ((i < 4) ? exp_ready[i] : 2'b00)) begin
        n_err++; $display("FAIL alt_grant[%0d] got %b exp %b", i, ia.m_ready, (i < 4) ? exp_ready[i] : 2'b00);
      end
      n_vec++;
      if ({ia.m_rvalid, ia.m_rdata} !== exp_rd[i]) begin
        n_err++; $display("FAIL alt_return[%0d] got %b %h exp %b %h", i, ia.m_rvalid, ia.m_rdata,
                          exp_rd[i][17:16], exp_rd[i][15:0]);
      end
    end
  endtask

  task automatic test_invalid_id();
    tick(); set_a(0, 1'b1, 3'd5, 8'h33, 8'h00, 1'b0); #1;
    n_vec++;
    if (ia.m_ready !== 2'b01) begin n_err++; $display("FAIL inv_rd_grant got %b exp 01", ia.m_ready); end
    tick(); idle_a(); #1;
    n_vec++;
    if ({ia.m_err, ia.bank_wren, ia.bank_addr} !== {2'b01, 2'b00, 16'h1010}) begin
      n_err++; $display("FAIL inv_rd_err got err=%b wren=%b addr=%h exp 01 00 1010", ia.m_err, ia.bank_wren, ia.bank_addr);
    end
    tick();
    n_vec++;
    if ({ia.m_err, ia.m_rvalid} !== 4'b0000) begin
      n_err++; $display("FAIL inv_rd_pulse got err=%b rvalid=%b exp 00 00", ia.m_err, ia.m_rvalid);
    end
    tick();
    n_vec++;
    if ({ia.m_rvalid, ia.m_rdata} !== {2'b01, 8'hA5, 8'h00}) begin
      n_err++; $display("FAIL inv_rd_return got %b %h exp 01 a500", ia.m_rvalid, ia.m_rdata);
    end
    set_a(1, 1'b1, 3'd6, 8'h44, 8'hFF, 1'b1); #1;
    n_vec++;
    if (ia.m_ready !== 2'b10) begin n_err++; $display("FAIL inv_wr_grant got %b exp 10", ia.m_ready); end
    tick(); idle_a(); #1;
    n_vec++;
    if ({ia.m_err, ia.bank_wren, ia.bank_addr} !== {2'b10, 2'b00, 16'h1010}) begin
      n_err++; $display("FAIL inv_wr_err got err=%b wren=%b addr=%h exp 10 00 1010", ia.m_err, ia.bank_wren, ia.bank_addr);
    end
    tick(); tick();
    n_vec++;
    if (ia.m_rvalid !== 2'b00) begin n_err++; $display("FAIL inv_wr_rvalid got %b exp 00", ia.m_rvalid); end
  endtask

  task automatic test_all_ones_id();
    logic [DW-1:0] exp_d;
    tick(); set_a(0, 1'b1, 3'd7, 8'h20, 8'h3C, 1'b1); #1;
    n_vec++;
    if (ia.m_ready !== 2'b01) begin n_err++; $display("FAIL ones_grant got %b exp 01", ia.m_ready); end
    tick(); idle_a(); #1;
`ifdef MEM_BANK_ROUTER_BCAST_EN
    exp_d = 8'h3C;
    n_vec++;
    if ({ia.bank_wren, ia.m_err, ia.bank_addr, ia.bank_data} !== {2'b11, 2'b00, 16'h2020, 16'h3C3C}) begin
      n_err++; $display("FAIL bcast_port got wren=%b err=%b addr=%h data=%h exp 11 00 2020 3c3c",
                        ia.bank_wren, ia.m_err, ia.bank_addr, ia.bank_data);
    end
`else
    exp_d = 8'h00;
    n_vec++;
    if ({ia.bank_wren, ia.m_err, ia.bank_addr} !== {2'b00, 2'b01, 16'h1010}) begin
      n_err++; $display("FAIL ones_invalid got wren=%b err=%b addr=%h exp 00 01 1010", ia.bank_wren, ia.m_err, ia.bank_addr);
    end
`endif
    tick();
    set_a(0, 1'b1, 3'd0, 8'h20, 8'h00, 1'b0);
    set_a(1, 1'b1, 3'd1, 8'h20, 8'h00, 1'b0); #1;
    n_vec++;
    if (ia.m_ready !== 2'b10) begin n_err++; $display("FAIL ones_rd_grant0 got %b exp 10", ia.m_ready); end
    tick(); set_a(1, 1'b0, '0, '0, '0, 1'b0); #1;
    n_vec++;
    if (ia.m_ready !== 2'b01) begin n_err++; $display("FAIL ones_rd_grant1 got %b exp 01", ia.m_ready); end
    tick(); idle_a(); #1;
    tick();
    n_vec++;
    if ({ia.m_rvalid, ia.m_rdata} !== {2'b10, exp_d, 8'h00}) begin
      n_err++; $display("FAIL ones_rd_m1 got %b %h exp 10 %h00", ia.m_rvalid, ia.m_rdata, exp_d);
    end
    tick();
    n_vec++;
    if ({ia.m_rvalid, ia.m_rdata} !== {2'b01, exp_d, exp_d}) begin
      n_err++; $display("FAIL ones_rd_m0 got %b %h exp 01 %h%h", ia.m_rvalid, ia.m_rdata, exp_d, exp_d);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]    exp_rv;
    logic [DW-1:0] exp_d;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (i < 3)      set_b(0, 1'b1, 3'd0, 8'(i), 8'((i + 1) * 17), 1'b1);
      else if (i < 6) set_b(0, 1'b1, 3'd0, 8'(i - 3), 8'h00, 1'b0);
      else            idle_b();
      #1;
      exp_rv = (i >= 8 && i <= 10) ? 2'b01 : 2'b00;
      if (i < 8)        exp_d = 8'h00;
      else if (i <= 10) exp_d = 8'((i - 7) * 17);
      else              exp_d = 8'h33;
      n_vec++;
      if (ib.m_ready !== ((i < 6) ? 2'b01 : 2'b00)) begin
        n_err++; $display("FAIL b2b_grant[%0d] got %b exp %b", i, ib.m_ready, (i < 6) ? 2'b01 : 2'b00);
      end
      n_vec++;
      if ({ib.m_rvalid, ib.m_rdata} !== {exp_rv, 8'h00, exp_d}) begin
        n_err++; $display("FAIL b2b_return[%0d] got %b %h exp %b 00%h", i, ib.m_rvalid, ib.m_rdata, exp_rv, exp_d);
      end
    end
  endtask

  task automatic test_reset_flush();
    tick(); set_a(1, 1'b1, 3'd0, 8'h10, 8'h00, 1'b0); #1;
    n_vec++;
    if (ia.m_ready !== 2'b10) begin n_err++; $display("FAIL flush_grant1 got %b exp 10", ia.m_ready); end
    tick(); idle_a(); set_a(0, 1'b1, 3'd1, 8'h10, 8'h00, 1'b0); #1;
    n_vec++;
    if (ia.m_ready !== 2'b01) begin n_err++; $display("FAIL flush_grant0 got %b exp 01", ia.m_ready); end
    tick(); idle_a();
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({ia.m_ready, ia.m_rvalid, ia.m_err, ia.bank_wren, ia.bank_addr, ia.bank_data, ia.m_rdata} !== '0) begin
      n_err++; $display("FAIL flush_zero got %b %b %b %b %h %h %h exp all zero", ia.m_ready, ia.m_rvalid, ia.m_err,
                        ia.bank_wren, ia.bank_addr, ia.bank_data, ia.m_rdata);
    end
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (ia.m_rvalid !== 2'b00) begin n_err++; $display("FAIL flush_rvalid[%0d] got %b exp 00", i, ia.m_rvalid); end
    end
    set_a(0, 1'b1, 3'd0, 8'h10, 8'h00, 1'b0);
    set_a(1, 1'b1, 3'd1, 8'h10, 8'h00, 1'b0); #1;
    n_vec++;
    if (ia.m_ready !== 2'b01) begin n_err++; $display("FAIL flush_ptr got %b exp 01", ia.m_ready); end
    tick(); idle_a();
  endtask

  initial begin
    idle_a();
    idle_b();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    test_reset();
    test_write_read();
    test_alternate();
    test_invalid_id();
    test_all_ones_id();
    test_back_to_back();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
